// File: rtl/axis_uart_tx.sv
// AXI-stream to UART transmitter: start bit, WIDTH data bits LSB first,
// optional parity bit, 1 or 2 stop bits, DIVISOR clocks per bit.
module axis_uart_tx #(
  parameter int WIDTH     = 8,
  parameter int DIVISOR   = 4,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] idata,
  input  logic             ivalid,
  output logic             iready,
  output logic             txd,
  output logic             busy
);

  localparam int CNT_W = $clog2(DIVISOR);
  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DIVISOR - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [IDX_W-1:0] LAST_DATA  = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] LAST_STOP  = IDX_W'(STOP_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  function automatic logic parity_init(input logic [WIDTH-1:0] d);
    return (^d) ^ (PARITY == 1);
  endfunction

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] shift;
  logic             par;
  logic             xfer;
  logic             tick;

  assign xfer = ivalid && iready;
  assign tick = (cnt == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      idx    <= '0;
      txd    <= 1'b1;
      iready <= 1'b0;
      busy   <= 1'b0;
    end else if (xfer) begin
      state  <= ST_START;
      cnt    <= CNT_RELOAD;
      idx    <= '0;
      txd    <= 1'b0;
      iready <= 1'b0;
      busy   <= 1'b1;
    end else begin
      if (state != ST_IDLE)
        cnt <= tick ? CNT_RELOAD : cnt - CNT_ONE;
      case (state)
        ST_IDLE: begin
          iready <= 1'b1;
          txd    <= 1'b1;
          busy   <= 1'b0;
        end
        ST_START:
          if (tick) begin
            state <= ST_DATA;
            txd   <= shift[0];
            idx   <= '0;
          end
        ST_DATA:
          if (tick) begin
            if (idx == LAST_DATA) begin
              if (PARITY != 0) begin
                state <= ST_PARITY;
                txd   <= par;
              end else begin
                state <= ST_STOP;
                txd   <= 1'b1;
                idx   <= '0;
              end
            end else begin
              txd <= shift[0];
              idx <= idx + IDX_ONE;
            end
          end
        ST_PARITY:
          if (tick) begin
            state <= ST_STOP;
            txd   <= 1'b1;
            idx   <= '0;
          end
        ST_STOP:
          if (tick) begin
            if (idx == LAST_STOP) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              idx <= idx + IDX_ONE;
            end
          // Raise iready one edge early so it is visible in the last stop cycle
          end else if (cnt == CNT_ONE && idx == LAST_STOP) begin
            iready <= 1'b1;
          end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Data path carries no reset: it is always reloaded at the transfer edge
  always_ff @(posedge clock) begin
    if (xfer) begin
      shift <= idata;
      par   <= parity_init(idata);
    end else if (tick && (state == ST_START || state == ST_DATA)) begin
      shift <= shift >> 1;
    end
  end

endmodule

// File: tb/tb_axis_uart_tx.sv
// Directed bench for axis_uart_tx: four instances cover no parity, even/odd
// parity and two stop bits with a shorter divisor.
module tb_axis_uart_tx;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clock = ~clock;

  logic [7:0] a_data = '0, e_data = '0, o_data = '0, s_data = '0;
  logic a_valid = 1'b0, e_valid = 1'b0, o_valid = 1'b0, s_valid = 1'b0;
  logic a_ready, e_ready, o_ready, s_ready;
  logic a_txd, e_txd, o_txd, s_txd;
  logic a_busy, e_busy, o_busy, s_busy;

  axis_uart_tx #(.WIDTH(8), .DIVISOR(4), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clock(clock), .reset(reset), .idata(a_data), .ivalid(a_valid),
    .iready(a_ready), .txd(a_txd), .busy(a_busy));
  axis_uart_tx #(.WIDTH(8), .DIVISOR(4), .PARITY(2), .STOP_BITS(1)) dut_e (
    .clock(clock), .reset(reset), .idata(e_data), .ivalid(e_valid),
    .iready(e_ready), .txd(e_txd), .busy(e_busy));
  axis_uart_tx #(.WIDTH(8), .DIVISOR(4), .PARITY(1), .STOP_BITS(1)) dut_o (
    .clock(clock), .reset(reset), .idata(o_data), .ivalid(o_valid),
    .iready(o_ready), .txd(o_txd), .busy(o_busy));
  axis_uart_tx #(.WIDTH(8), .DIVISOR(3), .PARITY(0), .STOP_BITS(2)) dut_s (
    .clock(clock), .reset(reset), .idata(s_data), .ivalid(s_valid),
    .iready(s_ready), .txd(s_txd), .busy(s_busy));

  task automatic test_reset;
    repeat (2) @(negedge clock);
    tests++;
    if ({a_txd, e_txd, o_txd, s_txd} !== 4'b1111) begin
      fails++; $display("FAIL reset_txd: got %b want 1111", {a_txd, e_txd, o_txd, s_txd});
    end
    tests++;
    if ({a_ready, e_ready, o_ready, s_ready} !== 4'b0000) begin
      fails++; $display("FAIL reset_iready: got %b want 0000", {a_ready, e_ready, o_ready, s_ready});
    end
    tests++;
    if ({a_busy, e_busy, o_busy, s_busy} !== 4'b0000) begin
      fails++; $display("FAIL reset_busy: got %b want 0000", {a_busy, e_busy, o_busy, s_busy});
    end
    reset = 1'b0;
  endtask

  task automatic test_idle;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      a_data = (k % 2 == 0) ? 8'hA5 : 8'h5A;
      tests++;
      if ({a_txd, a_busy, a_ready} !== 3'b101) begin
        fails++; $display("FAIL idle cycle %0d: txd/busy/iready got %b want 101", k, {a_txd, a_busy, a_ready});
      end
    end
  endtask

  task automatic test_single_frame;
    logic [9:0] bits;
    bits = {1'b1, 8'h55, 1'b0};
    @(negedge clock);
    a_data = 8'h55; a_valid = 1'b1;
    tests++;
    if (a_ready !== 1'b1) begin
      fails++; $display("FAIL single_ready_before: got %b want 1", a_ready);
    end
    @(posedge clock);
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      a_valid = 1'b0; a_data = 8'hFF;
      tests++;
      if (a_txd !== bits[k/4]) begin
        fails++; $display("FAIL single_txd cycle %0d: got %b want %b", k, a_txd, bits[k/4]);
      end
      tests++;
      if (a_busy !== 1'b1) begin
        fails++; $display("FAIL single_busy cycle %0d: got %b want 1", k, a_busy);
      end
      tests++;
      if (a_ready !== (k == 39)) begin
        fails++; $display("FAIL single_iready cycle %0d: got %b want %b", k, a_ready, (k == 39));
      end
    end
    @(negedge clock);
    tests++;
    if ({a_txd, a_busy, a_ready} !== 3'b101) begin
      fails++; $display("FAIL single_end: txd/busy/iready got %b want 101", {a_txd, a_busy, a_ready});
    end
  endtask

  task automatic test_back_to_back;
    logic [19:0] bits;
    int          ready_cnt;
    bits      = {1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0};
    ready_cnt = 0;
    @(negedge clock);
    a_data = 8'h00; a_valid = 1'b1;
    @(posedge clock);
    for (int k = 0; k < 80; k++) begin
      @(negedge clock);
      if (k == 0) a_data = 8'hFF;
      if (k == 40) begin a_valid = 1'b0; a_data = 8'h12; end
      if (a_ready === 1'b1) ready_cnt++;
      tests++;
      if (a_txd !== bits[k/4]) begin
        fails++; $display("FAIL b2b_txd cycle %0d: got %b want %b", k, a_txd, bits[k/4]);
      end
      tests++;
      if (a_busy !== 1'b1) begin
        fails++; $display("FAIL b2b_busy cycle %0d: got %b want 1", k, a_busy);
      end
      tests++;
      if (a_ready !== (k == 39 || k == 79)) begin
        fails++; $display("FAIL b2b_iready cycle %0d: got %b want %b", k, a_ready, (k == 39 || k == 79));
      end
    end
    tests++;
    if (ready_cnt != 2) begin
      fails++; $display("FAIL b2b_ready_count: got %0d want 2", ready_cnt);
    end
    @(negedge clock);
    tests++;
    if ({a_txd, a_busy, a_ready} !== 3'b101) begin
      fails++; $display("FAIL b2b_end: txd/busy/iready got %b want 101", {a_txd, a_busy, a_ready});
    end
  endtask

  task automatic test_parity;
    logic [10:0] bits_e, bits_o;
    bits_e = {1'b1, 1'b1, 8'h07, 1'b0};
    bits_o = {1'b1, 1'b0, 8'h07, 1'b0};
    @(negedge clock);
    e_data = 8'h07; e_valid = 1'b1;
    o_data = 8'h07; o_valid = 1'b1;
    @(posedge clock);
    for (int k = 0; k < 44; k++) begin
      @(negedge clock);
      e_valid = 1'b0; o_valid = 1'b0;
      tests++;
      if (e_txd !== bits_e[k/4]) begin
        fails++; $display("FAIL even_txd cycle %0d: got %b want %b", k, e_txd, bits_e[k/4]);
      end
      tests++;
      if (o_txd !== bits_o[k/4]) begin
        fails++; $display("FAIL odd_txd cycle %0d: got %b want %b", k, o_txd, bits_o[k/4]);
      end
      tests++;
      if ({e_ready, o_ready} !== {2{k == 43}}) begin
        fails++; $display("FAIL parity_iready cycle %0d: got %b want %b", k, {e_ready, o_ready}, {2{k == 43}});
      end
    end
    @(negedge clock);
    tests++;
    if ({e_busy, o_busy} !== 2'b00) begin
      fails++; $display("FAIL parity_end_busy: got %b want 00", {e_busy, o_busy});
    end
  endtask

  task automatic test_two_stop;
    logic [10:0] bits;
    bits = {2'b11, 8'hA5, 1'b0};
    @(negedge clock);
    s_data = 8'hA5; s_valid = 1'b1;
    @(posedge clock);
    for (int k = 0; k < 33; k++) begin
      @(negedge clock);
      s_valid = 1'b0;
      tests++;
      if (s_txd !== bits[k/3]) begin
        fails++; $display("FAIL stop2_txd cycle %0d: got %b want %b", k, s_txd, bits[k/3]);
      end
      tests++;
      if (s_busy !== 1'b1) begin
        fails++; $display("FAIL stop2_busy cycle %0d: got %b want 1", k, s_busy);
      end
      tests++;
      if (s_ready !== (k == 32)) begin
        fails++; $display("FAIL stop2_iready cycle %0d: got %b want %b", k, s_ready, (k == 32));
      end
    end
    @(negedge clock);
    tests++;
    if ({s_txd, s_busy, s_ready} !== 3'b101) begin
      fails++; $display("FAIL stop2_end: txd/busy/iready got %b want 101", {s_txd, s_busy, s_ready});
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [9:0] bits;
    bits = {1'b1, 8'h3C, 1'b0};
    @(negedge clock);
    a_data = 8'h0F; a_valid = 1'b1;
    @(posedge clock);
    for (int k = 0; k < 18; k++) begin
      @(negedge clock);
      a_valid = 1'b0;
    end
    tests++;
    if (a_txd !== 1'b1) begin
      fails++; $display("FAIL abort_pre_txd (data bit 3 of 0x0F): got %b want 1", a_txd);
    end
    reset = 1'b1;
    #1;
    tests++;
    if ({a_txd, a_busy, a_ready} !== 3'b100) begin
      fails++; $display("FAIL abort_async: txd/busy/iready got %b want 100", {a_txd, a_busy, a_ready});
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    tests++;
    if (a_ready !== 1'b0) begin
      fails++; $display("FAIL abort_release_ready: got %b want 0", a_ready);
    end
    @(negedge clock);
    tests++;
    if ({a_txd, a_busy, a_ready} !== 3'b101) begin
      fails++; $display("FAIL abort_first_edge: txd/busy/iready got %b want 101", {a_txd, a_busy, a_ready});
    end
    a_data = 8'h3C; a_valid = 1'b1;
    @(posedge clock);
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      a_valid = 1'b0; a_data = 8'h00;
      tests++;
      if (a_txd !== bits[k/4]) begin
        fails++; $display("FAIL refill_txd cycle %0d: got %b want %b", k, a_txd, bits[k/4]);
      end
    end
    @(negedge clock);
    tests++;
    if ({a_txd, a_busy, a_ready} !== 3'b101) begin
      fails++; $display("FAIL refill_end: txd/busy/iready got %b want 101", {a_txd, a_busy, a_ready});
    end
  endtask

  initial begin
    test_reset;
    test_idle;
    test_single_frame;
    test_back_to_back;
    test_parity;
    test_two_stop;
    test_reset_mid_frame;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
